// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix-keypad emulator: key indices, FSM states, matrix size.
// Key index is 4*row + col, matching what the keypad scanner reports as new_key_char.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef logic [3:0] key_t;
  typedef logic [7:0] hold_t;

  localparam key_t KEY_1 = 4'd0;
  localparam key_t KEY_2 = 4'd1;
  localparam key_t KEY_3 = 4'd2;
  localparam key_t KEY_A = 4'd3;
  localparam key_t KEY_4 = 4'd4;
  localparam key_t KEY_5 = 4'd5;
  localparam key_t KEY_6 = 4'd6;
  localparam key_t KEY_B = 4'd7;
  localparam key_t KEY_7 = 4'd8;
  localparam key_t KEY_8 = 4'd9;
  localparam key_t KEY_9 = 4'd10;
  localparam key_t KEY_C = 4'd11;
  localparam key_t KEY_0 = 4'd13;
  localparam key_t KEY_D = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // A zero hold would release before the scanner ever sees the key, so it means one frame.
  function automatic hold_t eff_hold(input hold_t hold);
    return (hold == 8'd0) ? 8'd1 : hold;
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Key-press command channel: valid/ready handshake carrying key index and hold length in frames.
// The source must hold cmd_valid and its payload stable until cmd_ready is seen high.
interface keypad_emulator_if;
  import keypad_pkg::*;

  logic  cmd_valid;
  logic  cmd_ready;
  key_t  cmd_key;
  hold_t cmd_hold;

  modport master (
    output cmd_valid,
    output cmd_key,
    output cmd_hold,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_key,
    input  cmd_hold,
    output cmd_ready
  );

endinterface

// File: rtl/keypad_emulator_scan_frame_detector.sv
// Detects scanner frame boundaries (row 3 strobe released) and times out when frames stop arriving.
// frame_edge is combinational from row3_n; expire is masked by a same-cycle frame edge.
module scan_frame_detector #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset_n,
  input  logic row3_n,
  input  logic active,
  output logic frame_edge,
  output logic expire
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic        row3_q;
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row3_q  <= 1'b1;
      tmo_cnt <= 16'd0;
    end else begin
      row3_q <= row3_n;
      if (!active || frame_edge) begin
        tmo_cnt <= 16'd0;
      end else begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end

  assign frame_edge = ~row3_q & row3_n;
  assign expire     = active & ~frame_edge & (tmo_cnt == TMO_LIMIT);

endmodule

// File: rtl/keypad_emulator.sv
// Drives keypad column lines low for a commanded key while its row is strobed, for N scan frames,
// then a release gap; one command at a time, cmd_ready low until done/timeout, col_n zero-latency to row_n.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned GAP_FRAMES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ROWS-1:0]    row_n,
  output logic [COLS-1:0]    col_n,
  keypad_emulator_if.slave   cmd,
  output logic               pressed,
  output logic               done,
  output logic               timeout
);

  localparam hold_t GAP_LIMIT = (GAP_FRAMES < 1) ? 8'd1 : 8'(GAP_FRAMES);

  state_t state_q, state_d;
  key_t   key_q,   key_d;
  hold_t  hold_q,  hold_d;
  hold_t  cnt_q,   cnt_d;
  logic   done_q,  done_d;
  logic   tmo_q,   tmo_d;

  logic   frame_edge;
  logic   expire;
  hold_t  cnt_inc;

  scan_frame_detector #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame (
    .clk        (clk),
    .reset_n    (reset_n),
    .row3_n     (row_n[ROWS-1]),
    .active     (state_q != ST_IDLE),
    .frame_edge (frame_edge),
    .expire     (expire)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      hold_q  <= 8'd1;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          state_d = ST_PRESS;
          key_d   = cmd.cmd_key;
          hold_d  = eff_hold(cmd.cmd_hold);
          cnt_d   = '0;
        end
      end
      ST_PRESS: begin
        if (frame_edge) begin
          if (cnt_inc >= hold_q) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (expire) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end
      end
      ST_GAP: begin
        if (frame_edge) begin
          if (cnt_inc >= GAP_LIMIT) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (expire) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign pressed       = (state_q == ST_PRESS);
  assign done          = done_q;
  assign timeout       = tmo_q;

  // Each strobed row is resolved independently, so several low rows never ghost onto other columns.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (pressed && (key_q == 4'(r * COLS + c)) && !row_n[r]) begin
          col_n[c] = 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Behavioural-to-RTL responder for the 4x4 matrix-keypad scan protocol: it watches the row strobes the keypad scanner drives on GPIO_1[7:4] and pulls the matching column line on GPIO_1[3:0] low for a commanded key. Used on-board and in benches to inject operand digits into the FP adder datapath without a physical keypad. It accepts one key-press command at a time, holds the key for a programmable number of complete scan frames, then releases it for a guard gap before accepting the next command.

## Interface
- GAP_FRAMES, 2: complete scan frames the key stays released after a press before `done`.
- TIMEOUT_CYCLES, 65535: max clocks between frame edges before the command is aborted (16-bit counter).
- clk  input  1  scan clock, same clock as the keypad scanner.
- reset_n  input  1  synchronous, active-low reset.
- row_n  input  4  resolved row lines (scanner drives one row 0, others float high via pull-up).
- col_n  output  4  column lines, active-low, to GPIO_1[3:0].
- cmd_valid  input  1  command present.
- cmd_ready  output  1  emulator idle, command can be taken.
- cmd_key  input  4  key index = 4*row + col (same index the scanner reports as `new_key_char`).
- cmd_hold  input  8  frames to hold the key pressed; 0 treated as 1.
- pressed  output  1  key currently asserted.
- done  output  1  one-cycle pulse: command completed normally.
- timeout  output  1  one-cycle pulse: command aborted, no frame edge within TIMEOUT_CYCLES.

## Operation
- Frame edge: rising edge of row_n[3] (row 3 strobe released), detected as registered row_n[3]=0 and current row_n[3]=1.
- States: IDLE, PRESS, GAP.
- IDLE: cmd_ready=1. On cmd_valid & cmd_ready latch key, hold (max(cmd_hold,1)), clear frame and timeout counters, go PRESS.
- PRESS: pressed=1. Each frame edge increments frame counter; on the edge that reaches hold, go GAP with counter cleared.
- GAP: pressed=0. On the GAP_FRAMES-th frame edge assert done for one cycle, go IDLE.
- Timeout counter: counts in PRESS/GAP, clears on every frame edge; at TIMEOUT_CYCLES-1 pulse timeout, go IDLE, pressed=0.
- col_n (combinational from row_n and registered state): col_n[c]=0 iff pressed, latched key = 4*r+c, and row_n[r]=0; otherwise 1. Multiple rows low: same rule per row, no ghosting.
- cmd_valid while not IDLE: ignored, cmd_ready=0; command must be held by the source.
- Keys 12 and 14 are legal indices (no scanner mapping); emulator presses them anyway.

## Timing
- Reset values: col_n=4'hF, cmd_ready=1, pressed=0, done=0, timeout=0, state IDLE, counters 0.
- Reset mid-PRESS or GAP: key released in the cycle after the reset edge, no done/timeout pulse.
- Command accepted at edge k: pressed=1 and col_n responsive from cycle k+1.
- col_n has zero-cycle latency to row_n: scanner drives a row low at edge n and samples columns at edge n+1; col_n must be valid before n+1.
- Release: pressed falls in the cycle after the hold-th frame edge.
- done: cycle after the GAP_FRAMES-th frame edge in GAP; cmd_ready=1 the same cycle, so back-to-back commands are spaced by one cycle minimum.
- Frame edge and timeout expiry in the same cycle: frame edge wins.

## Structure
- Package keypad_pkg: key index constants (KEY_1=0, KEY_2=1, KEY_3=2, KEY_A=3, KEY_4=4, KEY_5=5, KEY_6=6, KEY_B=7, KEY_7=8, KEY_8=9, KEY_9=10, KEY_C=11, KEY_0=13, KEY_D=15), state enum, ROWS=4, COLS=4.
- Sub-module scan_frame_detector: registers row_n[3], emits frame edge pulse, owns the timeout counter and expiry pulse.

## Test plan
- Reset: hold reset_n=0 two cycles -> col_n=4'hF, cmd_ready=1, pressed=0, done=timeout=0.
- cmd_key=5, cmd_hold=2, bench scanner cycling rows -> col_n=4'b1101 only while row_n=4'b1101, 4'hF on other rows; released after 2nd frame edge; done after 2 more frame edges.
- With the keypad scanner connected, command KEY_0 (13), hold 1 -> scanner raises new_key exactly once with new_key_char=13.
- cmd_hold=0 -> behaves as hold=1; cmd_valid raised while in GAP -> not accepted until done cycle.
- row_n stuck at 4'hF, TIMEOUT_CYCLES=16 -> timeout pulse 16 cycles after acceptance, no done, cmd_ready=1 next cycle.
- reset_n=0 while in PRESS on key 15 with row_n=4'b0111 -> col_n=4'hF after that edge, state IDLE, no pulses.
